sprite_row_fetcher: RTL and testbench

Scanline-driven reader for the 128×16 Pac-Man sprite ROM (4 directions × 16 rows, 64 words populated). Once per line it computes the sprite row for the current DrawY, issues the ROM address, captures the 16-bit row and serializes it into a per-pixel `pixel_on` for the colour mapper. Position and direction are latched once per frame so the sprite never tears mid-frame.

---
 rtl/sprite_row_fetcher.sv | 92 +++++++++
 tb/tb_sprite_row_fetcher.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_row_fetcher.sv
// sprite_row_fetcher: per-scanline sprite ROM row fetch and pixel serializer
module sprite_row_fetcher #(
  parameter int COORD_W = 10
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic               pixel_en,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COORD_W-1:0] PosX,
  input  logic [COORD_W-1:0] PosY,
  input  logic [1:0]         Dir,
  output logic [6:0]         rom_addr,
  input  logic [15:0]        rom_data,
  output logic               line_hit,
  output logic               pixel_on
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;
  logic [1:0]         state_q, state_d, dir_q, dir_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d, row;
  logic [15:0]        line_q, line_d, shift_q, shift_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [6:0]         rom_addr_q, rom_addr_d;
  logic               line_hit_q, line_hit_d, pixel_on_q, pixel_on_d, hit;
  always_comb begin
    px_d       = frame_start ? PosX : px_q;
    py_d       = frame_start ? PosY : py_q;
    dir_d      = frame_start ? Dir : dir_q;
    row        = DrawY - py_d;
    hit        = row < COORD_W'(16);
    state_d    = state_q;
    line_d     = line_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    line_hit_d = line_hit_q;
    pixel_on_d = pixel_on_q;
    if (line_start) begin
      state_d    = hit ? FETCH : IDLE;
      rom_addr_d = hit ? {1'b0, dir_d, 4'd15 - row[3:0]} : rom_addr_q;
      line_hit_d = 1'b0;
      pixel_on_d = 1'b0;
    end else if (state_q == FETCH) begin
      line_d     = rom_data;
      line_hit_d = 1'b1;
      state_d    = ARMED;
    end else if (state_q == ARMED && pixel_en && DrawX == px_q) begin
      pixel_on_d = line_q[15];
      shift_d    = {line_q[14:0], 1'b0};
      cnt_d      = 4'd0;
      state_d    = SHIFT;
    end else if (state_q == SHIFT && pixel_en) begin
      pixel_on_d = cnt_q != 4'd15 && shift_q[15];
      shift_d    = {shift_q[14:0], 1'b0};
      cnt_d      = cnt_q + 4'd1;
      state_d    = cnt_q == 4'd15 ? IDLE : SHIFT;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      px_q       <= '0;
      py_q       <= '0;
      dir_q      <= '0;
      line_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      line_hit_q <= 1'b0;
      pixel_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      dir_q      <= dir_d;
      line_q     <= line_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      line_hit_q <= line_hit_d;
      pixel_on_q <= pixel_on_d;
    end
  end
  assign rom_addr = rom_addr_q;
  assign line_hit = line_hit_q;
  assign pixel_on = pixel_on_q;
endmodule

// File: tb/tb_sprite_row_fetcher.sv
// tb_sprite_row_fetcher: randomized self-checking bench against a scanline-level sprite model
module tb_sprite_row_fetcher;
  logic        Clk = 0, Reset_n = 0, frame_start = 0, line_start = 0, pixel_en = 0;
  logic [9:0]  DrawX = 0, DrawY = 0, PosX = 0, PosY = 0;
  logic [1:0]  Dir = 0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data, cur_word;
  logic        line_hit, pixel_on, exp_pix;
  logic [15:0] rom [128];
  int          tests = 0, fails = 0, m_px = 0, m_py = 0, m_dir = 0, exp_addr = 0, cur_hit = 0;
  assign rom_data = rom[rom_addr];
  always #5 Clk = ~Clk;
  sprite_row_fetcher #(.COORD_W(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .line_start(line_start),
    .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
    .Dir(Dir), .rom_addr(rom_addr), .rom_data(rom_data), .line_hit(line_hit), .pixel_on(pixel_on)
  );
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic set_frame(input int px, input int py, input int dir);
    PosX = 10'(px);
    PosY = 10'(py);
    Dir = 2'(dir);
    frame_start = 1;
    tick();
    frame_start = 0;
    m_px = px;
    m_py = py;
    m_dir = dir;
    PosX = 10'($urandom);
    PosY = 10'($urandom);
    Dir = 2'($urandom);
  endtask
  task automatic start_line(input int y);
    int row;
    DrawY = 10'(y);
    line_start = 1;
    pixel_en = 0;
    tick();
    line_start = 0;
    frame_start = 0;
    row = (y - m_py) & 1023;
    cur_hit = row < 16 ? 1 : 0;
    if (cur_hit != 0) exp_addr = m_dir * 16 + 15 - row;
    cur_word = rom[exp_addr];
    tests++;
    if (rom_addr !== 7'(exp_addr)) begin fails++; $display("FAIL rom_addr y=%0d got %0d want %0d", y, rom_addr, exp_addr); end
    tests++;
    if (pixel_on !== 1'b0) begin fails++; $display("FAIL line_start_clear pixel_on got %b want 0", pixel_on); end
    tests++;
    if (line_hit !== 1'b0) begin fails++; $display("FAIL line_hit_early got %b want 0", line_hit); end
    tick();
    tests++;
    if (line_hit !== (cur_hit != 0)) begin fails++; $display("FAIL line_hit y=%0d got %b want %b", y, line_hit, cur_hit != 0); end
    tick();
    exp_pix = 0;
  endtask
  task automatic sweep(input int xs, input int xe, input bit sparse);
    int k;
    for (int x = xs; x <= xe; x++) begin
      if (sparse) begin
        repeat ($urandom_range(2)) begin
          pixel_en = 0;
          tick();
          tests++;
          if (pixel_on !== exp_pix) begin fails++; $display("FAIL hold x=%0d got %b want %b", x, pixel_on, exp_pix); end
        end
      end
      DrawX = 10'(x);
      pixel_en = 1;
      tick();
      pixel_en = 0;
      k = x - m_px;
      exp_pix = (cur_hit != 0 && k >= 0 && k < 16) ? cur_word[15-k] : 1'b0;
      tests++;
      if (pixel_on !== exp_pix) begin fails++; $display("FAIL pixel x=%0d got %b want %b", x, pixel_on, exp_pix); end
    end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
    rom[63] = 16'h0000;
    rom[61] = 16'h03C0;
    rom[9] = 16'h07FC;
    Reset_n = 0;
    #12;
    tests++;
    if (rom_addr !== 7'd0) begin fails++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    tests++;
    if (line_hit !== 1'b0) begin fails++; $display("FAIL reset_line_hit got %b want 0", line_hit); end
    tests++;
    if (pixel_on !== 1'b0) begin fails++; $display("FAIL reset_pixel_on got %b want 0", pixel_on); end
    @(negedge Clk);
    Reset_n = 1;
    tick();
  endtask
  task automatic test_down_rows();
    set_frame(200, 100, 3);
    start_line(100);
    sweep(196, 220, 0);
    start_line(102);
    sweep(196, 220, 1);
  endtask
  task automatic test_left_row6();
    set_frame(300, 50, 0);
    start_line(56);
    sweep(296, 320, 0);
  endtask
  task automatic test_miss_latch();
    set_frame(200, 200, 1);
    start_line(199);
    sweep(195, 220, 0);
    start_line(216);
    sweep(195, 220, 0);
    PosX = 10'd400;
    start_line(205);
    sweep(195, 420, 0);
  endtask
  task automatic test_abort();
    set_frame(150, 300, 2);
    start_line(303);
    sweep(146, 155, 0);
    start_line(310);
    sweep(146, 170, 1);
  endtask
  task automatic test_coincident();
    PosX = 10'd50;
    PosY = 10'd400;
    Dir = 2'd1;
    frame_start = 1;
    m_px = 50;
    m_py = 400;
    m_dir = 1;
    start_line(407);
    sweep(46, 70, 0);
  endtask
  task automatic test_edges();
    set_frame(630, 10, 3);
    start_line(12);
    sweep(626, 639, 0);
    start_line(13);
    sweep(626, 639, 1);
    set_frame(20, 30, 0);
    start_line(10);
    sweep(16, 40, 0);
    set_frame(20, 1020, 2);
    start_line(3);
    sweep(16, 40, 0);
  endtask
  task automatic test_random();
    int px, py;
    for (int f = 0; f < 12; f++) begin
      px = $urandom_range(639);
      py = $urandom_range(479);
      set_frame(px, py, $urandom_range(3));
      for (int l = 0; l < 3; l++) begin
        start_line((py + $urandom_range(19) - 2) & 1023);
        sweep(px >= 4 ? px - 4 : 0, px + 20 > 639 ? 639 : px + 20, 1'($urandom_range(1)));
      end
    end
  endtask
  task automatic test_reset_mid();
    set_frame(100, 100, 1);
    start_line(105);
    sweep(96, 108, 0);
    #2 Reset_n = 0;
    #1;
    tests++;
    if (pixel_on !== 1'b0) begin fails++; $display("FAIL midreset_pixel_on got %b want 0", pixel_on); end
    tests++;
    if (line_hit !== 1'b0) begin fails++; $display("FAIL midreset_line_hit got %b want 0", line_hit); end
    tests++;
    if (rom_addr !== 7'd0) begin fails++; $display("FAIL midreset_rom_addr got %0d want 0", rom_addr); end
    @(negedge Clk);
    Reset_n = 1;
    m_px = 0;
    m_py = 0;
    m_dir = 0;
    cur_hit = 0;
    exp_addr = 0;
    exp_pix = 0;
    sweep(0, 20, 0);
    start_line(5);
    sweep(0, 20, 1);
  endtask
  initial begin
    test_reset();
    test_down_rows();
    test_left_row6();
    test_miss_latch();
    test_abort();
    test_coincident();
    test_edges();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
